// File: rtl/shadow_context_engine.sv
// Saves and restores a shadow register bank to/from a stack frame in memory.
// Tracks nesting depth, pipelines restore reads, flags page-offset aliasing.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   save_i, restore_i    one-cycle triggers, sampled while ready_o
//   sp_i / sp_o          stack pointer in / resulting stack pointer
//   ready_o, done_o      idle flag / completion pulse
//   err_o                rejected-trigger pulse
//   level_o              current nesting depth
//   sreg_*               shadow register file read/write ports
//   mem_*                req/gnt/rvalid memory port, in-order responses
//   page_offset_*        LSU page offset alias check against active frame
//   csr_*                register file peek while idle
module shadow_context_engine #(
  parameter  int DATA_WIDTH      = 64,
  parameter  int NUM_REGS        = 16,
  parameter  int IDX_WIDTH       = $clog2(NUM_REGS),
  parameter  int MAX_NEST        = 4,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int WB              = DATA_WIDTH / 8,
  localparam int LW              = $clog2(MAX_NEST + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  save_i,
  input  logic                  restore_i,
  input  logic [DATA_WIDTH-1:0] sp_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] sp_o,
  output logic [LW-1:0]         level_o,
  output logic [IDX_WIDTH-1:0]  sreg_raddr_o,
  input  logic [DATA_WIDTH-1:0] sreg_rdata_i,
  output logic                  sreg_we_o,
  output logic [IDX_WIDTH-1:0]  sreg_waddr_o,
  output logic [DATA_WIDTH-1:0] sreg_wdata_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [WB-1:0]         mem_be_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic [11:0]           page_offset_i,
  output logic                  page_offset_match_o,
  input  logic [IDX_WIDTH-1:0]  csr_raddr_i,
  output logic [DATA_WIDTH-1:0] csr_rdata_o
);

  localparam int SH = $clog2(WB);
  localparam int CW = IDX_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] FRAME =
    DATA_WIDTH'(NUM_REGS * WB);
  localparam logic [11:0] LAST12 =
    12'((NUM_REGS - 1) * WB);
  localparam logic [11:0] WMASK =
    ~12'(WB - 1);

  typedef enum logic [1:0] {
    IDLE, SAVE, RESTORE, DRAIN
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] base;
  logic [IDX_WIDTH-1:0]  idx;
  logic [CW-1:0]         iss;
  logic [CW-1:0]         rsp;
  logic [2:0]            outst;
  logic [LW-1:0]         level;

  logic                  busy;
  logic                  grant;
  logic                  rsp_ok;
  logic [DATA_WIDTH-1:0] idx_off;
  logic [DATA_WIDTH-1:0] iss_off;
  logic [11:0]           lo12;
  logic [11:0]           hi12;
  logic [11:0]           po12;

  assign busy    = (state != IDLE);
  assign ready_o = ~busy;
  assign level_o = level;
  assign grant   = mem_req_o & mem_gnt_i;
  // Responses only count while a restore owns the port;
  // stragglers from an aborted restore fall on the floor.
  assign rsp_ok  = mem_rvalid_i &
                   ((state == RESTORE) | (state == DRAIN));

  assign idx_off = DATA_WIDTH'(idx) << SH;
  assign iss_off = DATA_WIDTH'(iss) << SH;

  // Word-granular window compare in the 4 KiB page.
  assign lo12 = base[11:0] & WMASK;
  assign hi12 = (base[11:0] + LAST12) & WMASK;
  assign po12 = page_offset_i & WMASK;

  assign page_offset_match_o =
    busy & (po12 >= lo12) & (po12 <= hi12);

  assign csr_rdata_o = busy ? {WB{8'haa}} : sreg_rdata_i;

  assign sreg_we_o    = rsp_ok;
  assign sreg_waddr_o = rsp[IDX_WIDTH-1:0];
  assign sreg_wdata_o = mem_rdata_i;
  assign mem_be_o     = '1;

  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    sreg_raddr_o = csr_raddr_i;
    unique case (state)
      SAVE: begin
        mem_req_o    = 1'b1;
        mem_we_o     = 1'b1;
        sreg_raddr_o = idx;
        mem_wdata_o  = sreg_rdata_i;
        mem_addr_o   = base + idx_off;
      end
      RESTORE: begin
        mem_req_o  = (outst < 3'(MAX_OUTSTANDING));
        mem_addr_o = base + iss_off;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      base   <= '0;
      idx    <= '0;
      iss    <= '0;
      rsp    <= '0;
      outst  <= '0;
      level  <= '0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      sp_o   <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (save_i) begin
            if (level == LW'(MAX_NEST)) begin
              err_o <= 1'b1;
            end else begin
              base  <= sp_i - FRAME;
              idx   <= IDX_WIDTH'(NUM_REGS - 1);
              state <= SAVE;
            end
          end else if (restore_i) begin
            if (level == '0) begin
              err_o <= 1'b1;
            end else begin
              base  <= sp_i;
              iss   <= '0;
              rsp   <= '0;
              outst <= '0;
              state <= RESTORE;
            end
          end
        end
        SAVE: begin
          if (mem_gnt_i) begin
            if (idx == '0) begin
              done_o <= 1'b1;
              sp_o   <= base;
              level  <= level + LW'(1);
              state  <= IDLE;
            end else begin
              idx <= idx - IDX_WIDTH'(1);
            end
          end
        end
        RESTORE: begin
          if (rsp_ok) rsp <= rsp + CW'(1);
          if (grant & ~rsp_ok) outst <= outst + 3'd1;
          if (~grant & rsp_ok) outst <= outst - 3'd1;
          if (grant) begin
            iss <= iss + CW'(1);
            if (iss == CW'(NUM_REGS - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rsp_ok) begin
            rsp   <= rsp + CW'(1);
            outst <= outst - 3'd1;
            if (rsp == CW'(NUM_REGS - 1)) begin
              done_o <= 1'b1;
              sp_o   <= base + FRAME;
              level  <= level - LW'(1);
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shadow_context_engine.sv
// Scoreboard bench for shadow_context_engine: directed save/restore
// sequences, memory/regfile models, queued expectations, async reset.
module tb_shadow_context_engine;

  localparam int NR = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        save_i, restore_i;
  logic [63:0] sp_i;
  logic        ready_o, done_o, err_o;
  logic [63:0] sp_o;
  logic [2:0]  level_o;
  logic [3:0]  sreg_raddr_o;
  logic [63:0] sreg_rdata_i;
  logic        sreg_we_o;
  logic [3:0]  sreg_waddr_o;
  logic [63:0] sreg_wdata_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_be_o;
  logic        mem_rvalid_i = 1'b0;
  logic [63:0] mem_rdata_i = '0;
  logic [11:0] page_offset_i;
  logic        page_offset_match_o;
  logic [3:0]  csr_raddr_i;
  logic [63:0] csr_rdata_o;

  always #5 clk_i = ~clk_i;

  shadow_context_engine #(
    .DATA_WIDTH(64), .NUM_REGS(16),
    .MAX_NEST(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .save_i(save_i), .restore_i(restore_i),
    .sp_i(sp_i), .ready_o(ready_o),
    .done_o(done_o), .err_o(err_o),
    .sp_o(sp_o), .level_o(level_o),
    .sreg_raddr_o(sreg_raddr_o),
    .sreg_rdata_i(sreg_rdata_i),
    .sreg_we_o(sreg_we_o),
    .sreg_waddr_o(sreg_waddr_o),
    .sreg_wdata_o(sreg_wdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .page_offset_i(page_offset_i),
    .page_offset_match_o(page_offset_match_o),
    .csr_raddr_i(csr_raddr_i),
    .csr_rdata_o(csr_rdata_o)
  );

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] d;
  } wr_t;
  typedef struct packed {
    logic [3:0]  i;
    logic [63:0] d;
  } rw_t;
  typedef struct packed {
    logic [63:0] sp;
    logic [2:0]  lv;
  } dn_t;
  typedef struct {
    logic [63:0] a;
    int          cnt;
  } rd_t;

  int          total = 0;
  int          bad = 0;
  logic [63:0] rf [NR];
  logic [63:0] mem [logic [63:0]];
  logic [63:0] img0 [NR];
  wr_t         exp_wr [$];
  rw_t         exp_rw [$];
  dn_t         exp_dn [$];
  rd_t         pend [$];
  int          exp_err = 0;
  int          gnt_mode = 0;
  int          inflight = 0;
  int          max_inflight = 0;
  logic [2:0]  exp_level = '0;

  assign sreg_rdata_i = rf[sreg_raddr_o];

  function automatic logic [63:0] pat(input int r);
    return 64'h0101_0101_0101_0101 * 64'(r + 1);
  endfunction

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rd_mem(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  // Memory side: grant policy and in-order read responses,
  // 3-cycle latency from grant edge to rvalid edge.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (pend.size() > 0 && pend[0].cnt == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rd_mem(pend[0].a);
        void'(pend.pop_front());
      end
      foreach (pend[k])
        if (pend[k].cnt > 0) pend[k].cnt--;
      case (gnt_mode)
        0: mem_gnt_i = 1'b1;
        1: mem_gnt_i = 1'($urandom_range(0, 1));
        3: begin
          if (mem_req_o) begin
            mem_gnt_i = 1'b1;
            gnt_mode  = 2;
          end else begin
            mem_gnt_i = 1'b0;
          end
        end
        default: mem_gnt_i = 1'b0;
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents a
  // transfer, register write, done or error.
  initial begin
    wr_t         e;
    rw_t         q;
    dn_t         d;
    logic        st_prev;
    logic [63:0] pa, pd;
    st_prev = 1'b0;
    pa = '0;
    pd = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        st_prev  = 1'b0;
        inflight = 0;
      end else begin
        if (st_prev) begin
          check("hold_req", 64'(mem_req_o), 64'h1);
          check("hold_addr", mem_addr_o, pa);
          check("hold_data", mem_wdata_o, pd);
        end
        st_prev = mem_req_o && !mem_gnt_i;
        pa = mem_addr_o;
        pd = mem_wdata_o;
        if (mem_rvalid_i) inflight--;
        if (mem_req_o && mem_gnt_i) begin
          if (mem_we_o) begin
            if (exp_wr.size() == 0) begin
              total++;
              bad++;
              $display("FAIL mem_write: unexpected addr %h",
                       mem_addr_o);
            end else begin
              e = exp_wr.pop_front();
              check("wr_addr", mem_addr_o, e.a);
              check("wr_data", mem_wdata_o, e.d);
              check("wr_be", 64'(mem_be_o), 64'hff);
            end
            mem[mem_addr_o] = mem_wdata_o;
          end else begin
            pend.push_back('{mem_addr_o, 2});
            inflight++;
            if (inflight > max_inflight)
              max_inflight = inflight;
          end
        end
        if (sreg_we_o) begin
          if (exp_rw.size() == 0) begin
            total++;
            bad++;
            $display("FAIL reg_write: unexpected idx %0d",
                     sreg_waddr_o);
          end else begin
            q = exp_rw.pop_front();
            check("rw_idx", 64'(sreg_waddr_o), 64'(q.i));
            check("rw_data", sreg_wdata_o, q.d);
          end
          rf[sreg_waddr_o] = sreg_wdata_o;
        end
        if (done_o) begin
          if (exp_dn.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done: unexpected sp %h", sp_o);
          end else begin
            d = exp_dn.pop_front();
            check("done_sp", sp_o, d.sp);
            check("done_level", 64'(level_o), 64'(d.lv));
          end
        end
        if (err_o) begin
          total++;
          if (exp_err == 0) begin
            bad++;
            $display("FAIL err: got 1 expected 0");
          end else begin
            exp_err--;
          end
        end
      end
    end
  end

  task automatic push_save(input logic [63:0] sp);
    for (int r = NR - 1; r >= 0; r--)
      exp_wr.push_back('{sp - 64'h80 + 64'(r * 8), pat(r)});
    exp_level++;
    exp_dn.push_back('{sp - 64'h80, exp_level});
  endtask

  task automatic push_restore(input logic [63:0] sp);
    for (int r = 0; r < NR; r++)
      exp_rw.push_back('{4'(r), pat(r)});
    exp_level--;
    exp_dn.push_back('{sp + 64'h80, exp_level});
  endtask

  task automatic trigger(input logic s, input logic r,
                         input logic [63:0] sp);
    @(posedge clk_i);
    #1;
    save_i    = s;
    restore_i = r;
    sp_i      = sp;
    @(posedge clk_i);
    #1;
    save_i    = 1'b0;
    restore_i = 1'b0;
  endtask

  task automatic run_op(input logic s, input logic r,
                        input logic [63:0] sp);
    bit ok;
    trigger(s, r, sp);
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk_i);
      if (ready_o) ok = 1'b1;
    end
    check("op_finish", 64'(ok), 64'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   errs;
    bit   seen;
    save_i        = 1'b0;
    restore_i     = 1'b0;
    sp_i          = '0;
    page_offset_i = 12'h000;
    csr_raddr_i   = '0;
    for (int r = 0; r < NR; r++) rf[r] = pat(r);

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", 64'(ready_o), 64'h1);
    check("rst_level", 64'(level_o), 64'h0);
    check("rst_done", 64'(done_o), 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    check("rst_req", 64'(mem_req_o), 64'h0);
    check("rst_we", 64'(sreg_we_o), 64'h0);
    check("rst_match", 64'(page_offset_match_o), 64'h0);
    check("rst_sp", sp_o, 64'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    csr_raddr_i = 4'd5;
    #1;
    check("csr_idle", csr_rdata_o, pat(5));

    // Restore with nothing saved is rejected.
    exp_err++;
    run_op(1'b0, 1'b1, 64'h1000);
    repeat (2) @(negedge clk_i);
    check("err_lvl0_seen", 64'(exp_err), 64'h0);
    check("err_lvl0_level", 64'(level_o), 64'h0);

    // Save from 0x1000 with a grant every cycle.
    push_save(64'h1000);
    page_offset_i = 12'hF88;
    trigger(1'b1, 1'b0, 64'h1000);
    n = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk_i);
      n++;
      if (n == 1) begin
        check("first_req", 64'(mem_req_o), 64'h1);
        check("first_addr", mem_addr_o, 64'hFF8);
      end
      if (n == 3) begin
        check("busy_ready", 64'(ready_o), 64'h0);
        check("match_in", 64'(page_offset_match_o), 64'h1);
        check("csr_busy", csr_rdata_o, 64'hAAAA_AAAA_AAAA_AAAA);
        page_offset_i = 12'h000;
        #1;
        check("match_out", 64'(page_offset_match_o), 64'h0);
      end
      if (done_o) seen = 1'b1;
    end
    check("save_cycles", 64'(n), 64'd17);
    for (int r = 0; r < NR; r++)
      img0[r] = rd_mem(64'hF80 + 64'(r * 8));

    // Restore from 0xF80, 3-cycle read latency.
    for (int r = 0; r < NR; r++) rf[r] = '0;
    max_inflight = 0;
    push_restore(64'hF80);
    run_op(1'b0, 1'b1, 64'hF80);
    check("max_inflight", 64'(max_inflight), 64'h2);
    errs = 0;
    for (int r = 0; r < NR; r++)
      if (rf[r] !== pat(r)) errs++;
    check("rf_restored", 64'(errs), 64'h0);
    check("restore_level", 64'(level_o), 64'h0);

    // Save again under random grant stalls.
    mem.delete();
    gnt_mode = 1;
    push_save(64'h1000);
    run_op(1'b1, 1'b0, 64'h1000);
    gnt_mode = 0;
    errs = 0;
    for (int r = 0; r < NR; r++)
      if (rd_mem(64'hF80 + 64'(r * 8)) !== img0[r]) errs++;
    check("stall_image", 64'(errs), 64'h0);

    // Nest to the limit.
    push_save(64'hF80);
    run_op(1'b1, 1'b0, 64'hF80);
    push_save(64'hF00);
    run_op(1'b1, 1'b0, 64'hF00);
    push_save(64'hE80);
    run_op(1'b1, 1'b0, 64'hE80);
    check("nest_full", 64'(level_o), 64'h4);

    exp_err++;
    run_op(1'b1, 1'b0, 64'hE00);
    repeat (2) @(negedge clk_i);
    check("err_full_seen", 64'(exp_err), 64'h0);
    check("err_full_level", 64'(level_o), 64'h4);

    push_restore(64'hE00);
    run_op(1'b0, 1'b1, 64'hE00);
    check("pop_level", 64'(level_o), 64'h3);

    // Simultaneous triggers: save wins, no error.
    push_save(64'hE80);
    run_op(1'b1, 1'b1, 64'hE80);
    check("both_level", 64'(level_o), 64'h4);

    push_restore(64'hE00);
    run_op(1'b0, 1'b1, 64'hE00);

    // Reset with one restore read outstanding.
    gnt_mode = 3;
    trigger(1'b0, 1'b1, 64'hE80);
    @(posedge clk_i);
    #1;
    check("one_inflight", 64'(inflight), 64'h1);
    rst_ni = 1'b0;
    exp_level = '0;
    @(negedge clk_i);
    check("mid_rst_ready", 64'(ready_o), 64'h1);
    check("mid_rst_level", 64'(level_o), 64'h0);
    check("mid_rst_req", 64'(mem_req_o), 64'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk_i);
      if (mem_rvalid_i) begin
        seen = 1'b1;
        check("late_rsp_we", 64'(sreg_we_o), 64'h0);
      end
    end
    check("late_rsp_seen", 64'(seen), 64'h1);
    check("post_rst_level", 64'(level_o), 64'h0);

    repeat (4) @(negedge clk_i);
    check("left_wr", 64'(exp_wr.size()), 64'h0);
    check("left_rw", 64'(exp_rw.size()), 64'h0);
    check("left_done", 64'(exp_dn.size()), 64'h0);
    check("left_err", 64'(exp_err), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
